// File: rtl/othello_pkg.sv
// Shared constants for the Othello turn controller: state codes, direction
// codes, side values and the tag recording which key led into KEY_REL.
package othello_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SELECT  = 4'd1;
    localparam logic [3:0] ST_KEY_REL = 4'd2;
    localparam logic [3:0] ST_DRAW    = 4'd3;
    localparam logic [3:0] ST_DETECT  = 4'd4;
    localparam logic [3:0] ST_FLIP    = 4'd5;
    localparam logic [3:0] ST_TURN    = 4'd6;
    localparam logic [3:0] ST_END     = 4'd7;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    typedef enum logic {
        TAG_PLACE = 1'b0,
        TAG_PASS  = 1'b1
    } tag_t;

endpackage

// File: rtl/othello_turn_ctrl_repeat_tick.sv
// Auto-repeat interval counter: counts down from REPEAT_DIV-1 while enabled and
// holds tick high at zero until the consumer reloads it.
module repeat_tick #(
    parameter int REPEAT_DIV = 12500000,
    parameter int REPEAT_W   = 28
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic reload,
    output logic tick
);

    localparam logic [REPEAT_W-1:0] RELOAD_VAL = REPEAT_W'(REPEAT_DIV - 1);

    logic [REPEAT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD_VAL;
        end else if (!enable || reload) begin
            count <= RELOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/othello_turn_ctrl.sv
// Othello turn sequencer: cursor, side, pass count and req/ack handshakes to the
// move detector, flipper and drawer. Define AUTO_REPEAT_EN for held-key repeat.
module othello_turn_ctrl
    import othello_pkg::*;
#(
    parameter int BOARD_W    = 8,
    parameter int BOARD_H    = 8,
    parameter int COORD_W    = 4,
    parameter int REPEAT_DIV = 12500000,
    parameter int REPEAT_W   = 28
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic               go,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               place,
    input  logic               pass,
    output logic               det_req,
    input  logic               det_ack,
    input  logic               det_legal,
    output logic               flip_req,
    input  logic               flip_done,
    input  logic               win,
    output logic               draw_req,
    input  logic               draw_done,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               side,
    output logic               game_over,
    output logic [3:0]         state
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(BOARD_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(BOARD_H - 1);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(BOARD_W / 2 - 1);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(BOARD_H / 2 - 1);

    if (BOARD_W < 2 || BOARD_W > 16 || BOARD_H < 2 || BOARD_H > 16 ||
        (1 << COORD_W) < BOARD_W || (1 << COORD_W) < BOARD_H ||
        REPEAT_DIV < 1 || REPEAT_W < 1 || (REPEAT_DIV >> REPEAT_W) != 0) begin : g_param_check
        $error("othello_turn_ctrl: invalid parameter set");
    end

    logic       draw_req_q;
    logic       det_req_q;
    logic       flip_req_q;
    logic [1:0] pass_cnt;
    tag_t       tag;
    logic       dir_lock;
    logic       any_dir;
    logic [1:0] sel_dir;
    logic       step_ok;
    logic       step_taken;

    assign any_dir = move_up | move_down | move_left | move_right;

    always_comb begin
        sel_dir = DIR_RIGHT;
        if (move_up) begin
            sel_dir = DIR_UP;
        end else if (move_down) begin
            sel_dir = DIR_DOWN;
        end else if (move_left) begin
            sel_dir = DIR_LEFT;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [1:0] last_dir;
    logic       rpt_tick;
    logic       rpt_enable;

    // The interval restarts whenever the held key goes away or changes.
    assign rpt_enable = dir_lock && any_dir && (sel_dir == last_dir);

    repeat_tick #(
        .REPEAT_DIV(REPEAT_DIV),
        .REPEAT_W  (REPEAT_W)
    ) u_repeat_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (rpt_enable),
        .reload (step_taken),
        .tick   (rpt_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dir <= DIR_UP;
        end else if (step_taken) begin
            last_dir <= sel_dir;
        end
    end

    assign step_ok = any_dir && (!dir_lock || rpt_tick);
`else
    assign step_ok = any_dir && !dir_lock;
`endif

    assign step_taken = !restart && (state == ST_SELECT) && !place && !pass && step_ok;

    // A key that caused a step (or left END) must be released before it steps again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_lock <= 1'b0;
        end else if (!any_dir) begin
            dir_lock <= 1'b0;
        end else if (step_taken || (!restart && state == ST_END)) begin
            dir_lock <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cur_x      <= X_INIT;
            cur_y      <= Y_INIT;
            side       <= BLACK;
            pass_cnt   <= 2'd0;
            tag        <= TAG_PLACE;
            draw_req_q <= 1'b0;
            det_req_q  <= 1'b0;
            flip_req_q <= 1'b0;
        end else if (restart) begin
            state      <= ST_IDLE;
            cur_x      <= X_INIT;
            cur_y      <= Y_INIT;
            side       <= BLACK;
            pass_cnt   <= 2'd0;
            tag        <= TAG_PLACE;
            draw_req_q <= 1'b0;
            det_req_q  <= 1'b0;
            flip_req_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_DRAW;
                        draw_req_q <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (place) begin
                        tag   <= TAG_PLACE;
                        state <= ST_KEY_REL;
                    end else if (pass) begin
                        tag   <= TAG_PASS;
                        state <= ST_KEY_REL;
                    end else if (step_ok) begin
                        case (sel_dir)
                            DIR_UP:    cur_y <= (cur_y == '0)   ? Y_MAX : cur_y - COORD_W'(1);
                            DIR_DOWN:  cur_y <= (cur_y == Y_MAX) ? '0    : cur_y + COORD_W'(1);
                            DIR_LEFT:  cur_x <= (cur_x == '0)   ? X_MAX : cur_x - COORD_W'(1);
                            default:   cur_x <= (cur_x == X_MAX) ? '0    : cur_x + COORD_W'(1);
                        endcase
                        state      <= ST_DRAW;
                        draw_req_q <= 1'b1;
                    end
                end
                ST_KEY_REL: begin
                    if (tag == TAG_PLACE && !place) begin
                        state     <= ST_DETECT;
                        det_req_q <= 1'b1;
                    end else if (tag == TAG_PASS && !pass) begin
                        pass_cnt <= pass_cnt + 2'd1;
                        state    <= ST_TURN;
                    end
                end
                ST_DRAW: begin
                    if (draw_done) begin
                        draw_req_q <= 1'b0;
                        state      <= ST_SELECT;
                    end
                end
                ST_DETECT: begin
                    if (det_ack) begin
                        det_req_q <= 1'b0;
                        if (det_legal) begin
                            state      <= ST_FLIP;
                            flip_req_q <= 1'b1;
                        end else begin
                            state <= ST_SELECT;
                        end
                    end
                end
                ST_FLIP: begin
                    if (flip_done) begin
                        flip_req_q <= 1'b0;
                        pass_cnt   <= 2'd0;
                        state      <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (win || pass_cnt == 2'd2) begin
                        state <= ST_END;
                    end else begin
                        side       <= (side == BLACK) ? WHITE : BLACK;
                        state      <= ST_DRAW;
                        draw_req_q <= 1'b1;
                    end
                end
                ST_END: begin
                    if (any_dir || go) begin
                        state    <= ST_IDLE;
                        cur_x    <= X_INIT;
                        cur_y    <= Y_INIT;
                        side     <= BLACK;
                        pass_cnt <= 2'd0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    draw_req_q <= 1'b0;
                    det_req_q  <= 1'b0;
                    flip_req_q <= 1'b0;
                end
            endcase
        end
    end

    // restart must silence the handshakes in the same cycle it is raised.
    assign draw_req  = draw_req_q & ~restart;
    assign det_req   = det_req_q & ~restart;
    assign flip_req  = flip_req_q & ~restart;
    assign game_over = (state == ST_END);

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Self-checking bench for othello_turn_ctrl (default build, AUTO_REPEAT_EN undefined):
// directed scenarios plus randomized play against a behavioural board/turn model.
module tb_othello_turn_ctrl;
    import othello_pkg::*;

    localparam int BW = 8;
    localparam int BH = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       restart, go;
    logic       move_up, move_down, move_left, move_right;
    logic       place, pass;
    logic       det_req, det_ack, det_legal;
    logic       flip_req, flip_done, win;
    logic       draw_req, draw_done;
    logic [3:0] cur_x, cur_y;
    logic       side, game_over;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers and modulo arithmetic.
    int m_st    = ST_IDLE;
    int mx      = BW / 2 - 1;
    int my      = BH / 2 - 1;
    int ms      = 0;
    int mp      = 0;
    int m_tag   = 0;
    bit m_armed = 1'b1;

    bit flip_seen;

    othello_turn_ctrl #(
        .BOARD_W(BW), .BOARD_H(BH), .COORD_W(4), .REPEAT_DIV(12500000), .REPEAT_W(28)
    ) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .go(go),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .place(place), .pass(pass),
        .det_req(det_req), .det_ack(det_ack), .det_legal(det_legal),
        .flip_req(flip_req), .flip_done(flip_done), .win(win),
        .draw_req(draw_req), .draw_done(draw_done),
        .cur_x(cur_x), .cur_y(cur_y), .side(side), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReinit();
        mx = BW / 2 - 1;
        my = BH / 2 - 1;
        ms = 0;
        mp = 0;
    endtask

    task automatic modelStep();
        bit any_k, stepped, end_dir;
        if (!reset_n) begin
            m_st = ST_IDLE; modelReinit(); m_tag = 0; m_armed = 1'b1;
            return;
        end
        any_k   = move_up | move_down | move_left | move_right;
        stepped = 1'b0;
        end_dir = 1'b0;
        if (restart) begin
            m_st = ST_IDLE; modelReinit();
        end else begin
            case (m_st)
                ST_IDLE:   if (go) m_st = ST_DRAW;
                ST_SELECT: begin
                    if (place) begin m_tag = 0; m_st = ST_KEY_REL; end
                    else if (pass) begin m_tag = 1; m_st = ST_KEY_REL; end
                    else if (any_k && m_armed) begin
                        if (move_up)        my = (my + BH - 1) % BH;
                        else if (move_down) my = (my + 1) % BH;
                        else if (move_left) mx = (mx + BW - 1) % BW;
                        else                mx = (mx + 1) % BW;
                        stepped = 1'b1;
                        m_st = ST_DRAW;
                    end
                end
                ST_KEY_REL: begin
                    if (m_tag == 0 && !place) m_st = ST_DETECT;
                    else if (m_tag == 1 && !pass) begin mp = mp + 1; m_st = ST_TURN; end
                end
                ST_DRAW:   if (draw_done) m_st = ST_SELECT;
                ST_DETECT: if (det_ack) m_st = det_legal ? ST_FLIP : ST_SELECT;
                ST_FLIP:   if (flip_done) begin mp = 0; m_st = ST_TURN; end
                ST_TURN: begin
                    if (win || mp >= 2) m_st = ST_END;
                    else begin ms = 1 - ms; m_st = ST_DRAW; end
                end
                ST_END: begin
                    if (any_k || go) begin
                        modelReinit();
                        m_st = ST_IDLE;
                        end_dir = any_k;
                    end
                end
                default: m_st = ST_IDLE;
            endcase
        end
        if (!any_k) m_armed = 1'b1;
        else if (stepped || end_dir) m_armed = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            modelStep();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checkOutput("state", state, m_st);
        checkOutput("cur_x", cur_x, mx);
        checkOutput("cur_y", cur_y, my);
        checkOutput("side", side, ms);
        checkOutput("game_over", game_over, m_st == ST_END);
        checkOutput("draw_req", draw_req, m_st == ST_DRAW && !restart);
        checkOutput("det_req", det_req, m_st == ST_DETECT && !restart);
        checkOutput("flip_req", flip_req, m_st == ST_FLIP && !restart);
        if (flip_req) flip_seen = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dirs, input logic pl, input logic ps, input logic g);
        {move_up, move_down, move_left, move_right} = dirs;
        place = pl;
        pass  = ps;
        go    = g;
    endtask

    task automatic finishDraw();
        int guard;
        for (guard = 0; guard < 20 && !draw_req; guard++) cyc(1);
        if (guard >= 20) checkOutput("draw_req_timeout", 0, 1);
        draw_done = 1'b1;
        cyc(1);
        draw_done = 1'b0;
    endtask

    task automatic pressOnce(input logic [3:0] dirs);
        applyStimulus(dirs, 0, 0, 0);
        cyc(1);
        applyStimulus(4'b0000, 0, 0, 0);
        finishDraw();
    endtask

    initial begin
        int cnt;
        logic [3:0] keys;
        reset_n = 1'b0; restart = 0; win = 0; det_legal = 0;
        det_ack = 0; flip_done = 0; draw_done = 0; flip_seen = 0;
        applyStimulus(4'b0000, 0, 0, 0);
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        checkOutput("reset_state", state, ST_IDLE);
        checkOutput("reset_cur_x", cur_x, 3);
        checkOutput("reset_cur_y", cur_y, 3);
        checkOutput("reset_reqs", {draw_req, det_req, flip_req, game_over}, 0);

        // Start game; drawer answers in the third request cycle.
        applyStimulus(4'b0000, 0, 0, 1);
        cyc(1);
        go = 0;
        cnt = 0;
        for (int i = 0; i < 10 && draw_req; i++) begin
            cnt++;
            if (cnt == 3) draw_done = 1'b1;
            cyc(1);
            draw_done = 1'b0;
        end
        checkOutput("draw_req_cycles", cnt, 3);
        checkOutput("start_state", state, ST_SELECT);

        // Walk to (0,0), then wrap left and hold.
        for (int i = 0; i < 3; i++) pressOnce(4'b1000);
        for (int i = 0; i < 3; i++) pressOnce(4'b0010);
        checkOutput("origin_x", cur_x, 0);
        checkOutput("origin_y", cur_y, 0);
        applyStimulus(4'b0010, 0, 0, 0);
        cyc(1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (draw_req) begin cnt++; draw_done = 1'b1; end
            cyc(1);
            draw_done = 1'b0;
        end
        applyStimulus(4'b0000, 0, 0, 0);
        cyc(1);
        checkOutput("wrap_x", cur_x, 7);
        checkOutput("wrap_y", cur_y, 0);
        checkOutput("held_draws", cnt, 1);

        // Illegal placement.
        flip_seen = 0;
        applyStimulus(4'b0000, 1, 0, 0); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0); cyc(1);
        checkOutput("det_req_up", det_req, 1);
        det_ack = 1; det_legal = 0; cyc(1);
        det_ack = 0; cyc(2);
        checkOutput("illegal_state", state, ST_SELECT);
        checkOutput("illegal_side", side, 0);
        checkOutput("illegal_no_flip", flip_seen, 0);

        // Legal placement.
        applyStimulus(4'b0000, 1, 0, 0); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0); cyc(1);
        det_ack = 1; det_legal = 1; cyc(1);
        det_ack = 0; cyc(2);
        flip_done = 1; cyc(1);
        flip_done = 0;
        checkOutput("turn_state", state, ST_TURN);
        cyc(1);
        checkOutput("turn_side", side, 1);
        checkOutput("turn_draw_req", draw_req, 1);
        finishDraw();

        // Both sides pass.
        applyStimulus(4'b0000, 0, 1, 0); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0); cyc(2);
        finishDraw();
        checkOutput("after_pass_side", side, 0);
        applyStimulus(4'b0000, 0, 1, 0); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0); cyc(2);
        checkOutput("end_game_over", game_over, 1);
        applyStimulus(4'b0000, 0, 0, 1); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0);
        checkOutput("end_exit_state", state, ST_IDLE);
        checkOutput("end_exit_cur", {cur_x, cur_y}, 8'h33);
        checkOutput("end_exit_side", side, 0);

        // Asynchronous reset during FLIP, then a stray flip_done.
        applyStimulus(4'b0000, 0, 0, 1); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0);
        finishDraw();
        applyStimulus(4'b0000, 1, 0, 0); cyc(1);
        applyStimulus(4'b0000, 0, 0, 0); cyc(1);
        det_ack = 1; det_legal = 1; cyc(1);
        det_ack = 0;
        checkOutput("flip_req_up", flip_req, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("flip_req_async_drop", flip_req, 0);
        cyc(1);
        reset_n = 1'b1;
        flip_done = 1; cyc(1);
        flip_done = 0;
        checkOutput("late_done_state", state, ST_IDLE);
        checkOutput("late_done_flip_req", flip_req, 0);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            reset_n   = ($urandom_range(0, 599) != 0);
            restart   = ($urandom_range(0, 299) == 0);
            go        = ($urandom_range(0, 3) == 0);
            place     = ($urandom_range(0, 11) == 0);
            pass      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 7) == 0) keys = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 1) == 0) keys = 4'b0000;
                else keys = 4'(1 << $urandom_range(0, 3));
                {move_up, move_down, move_left, move_right} = keys;
            end
            draw_done = ($urandom_range(0, 2) == 0);
            det_ack   = ($urandom_range(0, 2) == 0);
            det_legal = 1'($urandom_range(0, 1));
            flip_done = ($urandom_range(0, 2) == 0);
            win       = ($urandom_range(0, 7) == 0);
            cyc(1);
        end

        reset_n = 1'b1; restart = 0; win = 0; det_ack = 0; flip_done = 0; draw_done = 0;
        applyStimulus(4'b0000, 0, 0, 0);
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
